// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - pin/config/request bundle between SoC, core and interrupt_controller
// master drives the IRQ lines, acknowledge and config port; slave is the controller.
interface interrupt_controller_if;
  logic [1:0] IRQ_Ext;
  logic       IntAck;
  logic       CfgWe;
  logic       CfgClr;
  logic [1:0] CfgData;
  logic       IRQ_Int;
  logic       IID_Sync;
  logic [1:0] PendingOut;
  logic [1:0] MaskOut;

  modport master (
    output IRQ_Ext, IntAck, CfgWe, CfgClr, CfgData,
    input  IRQ_Int, IID_Sync, PendingOut, MaskOut
  );

  modport slave (
    input  IRQ_Ext, IntAck, CfgWe, CfgClr, CfgData,
    output IRQ_Int, IID_Sync, PendingOut, MaskOut
  );
endinterface

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - two-source edge-latched interrupt controller with ack gap
// Define INTC_RR_ARB_EN for round-robin arbitration instead of fixed priority (source 0 first).
module interrupt_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input logic                  Clock,
  input logic                  SysReset,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} stateType;

  localparam logic [3:0] GapLoad = 4'(GAP_CYCLES);

  logic [1:0] syncFf [SYNC_STAGES];
  logic [1:0] histFf;
  logic [1:0] pending;
  logic [1:0] mask;
  stateType   state;
  logic [3:0] gapCnt;
  logic       irqInt;
  logic       iidSync;

  logic [1:0] rise;
  logic [1:0] eligible;
  logic [1:0] cfgClrBits;
  logic [1:0] ackClrBits;
  logic [1:0] pendingNext;
  logic [1:0] maskNext;
  logic [1:0] eligibleNext;
  logic       ackTaken;
  logic       grantId;

  assign rise         = syncFf[SYNC_STAGES-1] & ~histFf;
  assign eligible     = pending & mask;
  assign ackTaken     = (state == REQ) && bus.IntAck;
  assign cfgClrBits   = bus.CfgClr ? bus.CfgData : 2'b00;
  assign ackClrBits   = ackTaken ? (iidSync ? 2'b10 : 2'b01) : 2'b00;
  // A rise in the same cycle as any clear wins, so no event is ever lost.
  assign pendingNext  = (pending & ~(cfgClrBits | ackClrBits)) | rise;
  assign maskNext     = bus.CfgWe ? bus.CfgData : mask;
  assign eligibleNext = pendingNext & maskNext;

`ifdef INTC_RR_ARB_EN
  logic lastGrant;

  assign grantId = (eligible == 2'b11) ? ~lastGrant : ~eligible[0];

  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      lastGrant <= 1'b1;
    end else if (ackTaken) begin
      lastGrant <= iidSync;
    end
  end
`else
  assign grantId = ~eligible[0];
`endif

  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        syncFf[i] <= 2'b00;
      end
      histFf  <= 2'b00;
      pending <= 2'b00;
      mask    <= 2'b00;
    end else begin
      syncFf[0] <= bus.IRQ_Ext;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncFf[i] <= syncFf[i-1];
      end
      histFf  <= syncFf[SYNC_STAGES-1];
      pending <= pendingNext;
      mask    <= maskNext;
    end
  end

  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      state   <= IDLE;
      gapCnt  <= 4'd0;
      irqInt  <= 1'b0;
      iidSync <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible != 2'b00) begin
            state   <= REQ;
            irqInt  <= 1'b1;
            iidSync <= grantId;
          end
        end
        REQ: begin
          // Acknowledge beats a same-cycle mask/clear; withdrawal looks at next-cycle eligibility.
          if (bus.IntAck) begin
            irqInt <= 1'b0;
            gapCnt <= GapLoad;
            state  <= GAP;
          end else if (!eligibleNext[iidSync]) begin
            irqInt <= 1'b0;
            state  <= IDLE;
          end
        end
        GAP: begin
          gapCnt <= gapCnt - 4'd1;
          if (gapCnt <= 4'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          irqInt <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IRQ_Int    = irqInt;
  assign bus.IID_Sync   = iidSync;
  assign bus.PendingOut = pending;
  assign bus.MaskOut    = mask;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed vector bench for interrupt_controller
// Each table row is one clock: inputs driven at negedge, outputs checked 1 ns after posedge.
module tb_interrupt_controller;

  typedef struct {
    logic [1:0] ext;
    logic       ack;
    logic       we;
    logic       clr;
    logic [1:0] data;
    logic       expIrq;
    logic       expIid;
    logic [1:0] expPend;
    logic [1:0] expMask;
  } rowType;

  logic Clock;
  logic SysReset;
  int   testCount;
  int   failCount;
  rowType rows[$];

  interrupt_controller_if bus();

  interrupt_controller #(
    .SYNC_STAGES(2),
    .GAP_CYCLES (2)
  ) dut (
    .Clock   (Clock),
    .SysReset(SysReset),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic addRow(input logic [1:0] ext, input logic ack, input logic we, input logic clr,
                        input logic [1:0] data, input logic irq, input logic iid,
                        input logic [1:0] pend, input logic [1:0] msk);
    rowType r;
    r.ext = ext; r.ack = ack; r.we = we; r.clr = clr; r.data = data;
    r.expIrq = irq; r.expIid = iid; r.expPend = pend; r.expMask = msk;
    rows.push_back(r);
  endtask

  task automatic checkOut(input string name, input logic irq, input logic iid,
                          input logic [1:0] pend, input logic [1:0] msk);
    testCount++;
    if (bus.IRQ_Int !== irq || bus.IID_Sync !== iid || bus.PendingOut !== pend || bus.MaskOut !== msk) begin
      failCount++;
      $display("FAIL %s: got irq=%b iid=%b pend=%b mask=%b, want irq=%b iid=%b pend=%b mask=%b",
               name, bus.IRQ_Int, bus.IID_Sync, bus.PendingOut, bus.MaskOut, irq, iid, pend, msk);
    end
  endtask

  task automatic driveIdle();
    bus.IRQ_Ext = 2'b00; bus.IntAck = 1'b0; bus.CfgWe = 1'b0; bus.CfgClr = 1'b0; bus.CfgData = 2'b00;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    driveIdle();
    SysReset = 1'b0;

    //      ext   ack we clr data   irq iid pend   mask
    // Single source, mask 01: latency, hold, ack, gap
    addRow(2'b00, 0, 1, 0, 2'b01,  0, 0, 2'b00, 2'b01);
    addRow(2'b01, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b01, 2'b01);
    addRow(2'b00, 1, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    // Both sources together, twice
    addRow(2'b00, 0, 1, 0, 2'b11,  0, 0, 2'b00, 2'b11);
    for (int k = 0; k < 2; k++) begin
      addRow(2'b11, 0, 0, 0, 2'b00,  0, k[0], 2'b00, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  0, k[0], 2'b00, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  0, k[0], 2'b11, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b11, 2'b11);
      addRow(2'b00, 1, 0, 0, 2'b00,  0, 0, 2'b10, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b10, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b10, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  1, 1, 2'b10, 2'b11);
      addRow(2'b00, 1, 0, 0, 2'b00,  0, 1, 2'b00, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b11);
      addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b11);
    end
    // Mask out locked source 0 while in REQ: withdraw, then present source 1
    addRow(2'b11, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b11);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b11);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b11, 2'b11);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b11, 2'b11);
    addRow(2'b00, 0, 1, 0, 2'b10,  0, 0, 2'b11, 2'b10);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 1, 2'b11, 2'b10);
    addRow(2'b00, 1, 0, 0, 2'b00,  0, 1, 2'b01, 2'b10);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b01, 2'b10);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b01, 2'b10);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b01, 2'b10);
    addRow(2'b00, 0, 0, 1, 2'b01,  0, 1, 2'b00, 2'b10);
    // New rise on source 0 coincident with its ack: re-presented 3 edges later
    addRow(2'b00, 0, 1, 0, 2'b01,  0, 1, 2'b00, 2'b01);
    addRow(2'b01, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b01, 2'b01);
    addRow(2'b01, 0, 0, 0, 2'b00,  1, 0, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b01, 2'b01);
    addRow(2'b00, 1, 0, 0, 2'b00,  0, 0, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b01, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 0, 2'b01, 2'b01);
    addRow(2'b00, 1, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b01);
    // Masked source latches pending; enable presents it; CfgClr withdraws it
    addRow(2'b00, 0, 1, 0, 2'b00,  0, 0, 2'b00, 2'b00);
    addRow(2'b10, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b00);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b00, 2'b00);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b10, 2'b00);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 0, 2'b10, 2'b00);
    addRow(2'b00, 0, 1, 0, 2'b10,  0, 0, 2'b10, 2'b10);
    addRow(2'b00, 0, 0, 0, 2'b00,  1, 1, 2'b10, 2'b10);
    addRow(2'b00, 0, 0, 1, 2'b10,  0, 1, 2'b00, 2'b10);
    // Stray ack in IDLE ignored; CfgWe and CfgClr together both apply
    addRow(2'b00, 1, 0, 0, 2'b00,  0, 1, 2'b00, 2'b10);
    addRow(2'b00, 0, 1, 1, 2'b11,  0, 1, 2'b00, 2'b11);
    addRow(2'b00, 0, 0, 0, 2'b00,  0, 1, 2'b00, 2'b11);

    #3;
    checkOut("reset_state", 0, 0, 2'b00, 2'b00);
    @(negedge Clock);
    @(negedge Clock);
    SysReset = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge Clock);
      bus.IRQ_Ext = rows[i].ext;
      bus.IntAck  = rows[i].ack;
      bus.CfgWe   = rows[i].we;
      bus.CfgClr  = rows[i].clr;
      bus.CfgData = rows[i].data;
      @(posedge Clock);
      #1;
      checkOut($sformatf("row%0d", i), rows[i].expIrq, rows[i].expIid, rows[i].expPend, rows[i].expMask);
    end

    // Asynchronous reset while a request is presented
    @(negedge Clock);
    driveIdle();
    bus.CfgWe = 1'b1; bus.CfgData = 2'b01;
    @(negedge Clock);
    driveIdle();
    bus.IRQ_Ext = 2'b01;
    @(negedge Clock);
    bus.IRQ_Ext = 2'b00;
    begin
      int waitCycles = 0;
      while (bus.IRQ_Int !== 1'b1 && waitCycles < 10) begin
        @(negedge Clock);
        waitCycles++;
      end
    end
    checkOut("req_before_reset", 1, 0, 2'b01, 2'b01);
    #2;
    SysReset = 1'b0;
    #1;
    checkOut("async_reset_in_req", 0, 0, 2'b00, 2'b00);
    @(negedge Clock);
    SysReset = 1'b1;
    @(posedge Clock);
    #1;
    checkOut("after_reset_release", 0, 0, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
